// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared widths and payload types for the GPR write-port arbiter.
//   XLEN         : register data width
//   RADDR_W      : register address width
//   NUM_REGS     : architectural register count (x0 hard-wired zero)
//   STARVE_LIMIT : cycles a buffered long-latency result may lose to WB
//   CNT_W        : width of the starvation counter
package gpr_wb_arbiter_pkg;

    localparam int unsigned XLEN         = 64;
    localparam int unsigned RADDR_W      = 5;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1);

    // Long-latency result held while waiting for the write port.
    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    data;
    } ll_result_t;

endpackage

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard for long-latency ops plus decode hazard check.
//   clk, rst        : clock, synchronous active-high reset
//   set_en_i/set_rd_i : mark rd pending (long-latency op leaves decode)
//   clr_en_i/clr_rd_i : clear rd (its result reaches the write port)
//   id_*_i          : decode operands and destination
//   id_stall_o      : RAW/WAW hazard against a pending register
//   pending_o       : scoreboard vector, bit 0 always zero
module gpr_wb_arbiter_scoreboard
    import gpr_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en_i,
    input  logic [RADDR_W-1:0]  set_rd_i,
    input  logic                clr_en_i,
    input  logic [RADDR_W-1:0]  clr_rd_i,
    input  logic                id_valid_i,
    input  logic [RADDR_W-1:0]  id_rs1_i,
    input  logic [RADDR_W-1:0]  id_rs2_i,
    input  logic [RADDR_W-1:0]  id_rd_i,
    input  logic                id_rd_wen_i,
    output logic                id_stall_o,
    output logic [NUM_REGS-1:0] pending_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear first so a same-cycle set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_rd_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign id_stall_o = id_valid_i &&
                        (pending_q[id_rs1_i] || pending_q[id_rs2_i] ||
                         (id_rd_wen_i && pending_q[id_rd_i]));
    assign pending_o  = pending_q;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates the single GPR write port between the in-order WB stage and a
// one-entry buffer of out-of-order long-latency results, with a starvation
// bound that holds WB once the buffered result has waited STARVE_LIMIT cycles.
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : decode operands; id_stall asks decode to hold
//   ll_issue/_rd      : long-latency op leaving decode (marks rd pending)
//   ll_resp_*         : long-latency result handshake (ready = buffer empty)
//   wb_en/addr/data   : WB stage write; wb_hold asks WB to retry next cycle
//   rf_wr_*           : regfile write port
//   pending           : scoreboard vector
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [RADDR_W-1:0]  id_rs1_addr,
    input  logic [RADDR_W-1:0]  id_rs2_addr,
    input  logic [RADDR_W-1:0]  id_rd_addr,
    input  logic                id_rd_wen,
    output logic                id_stall,
    input  logic                ll_issue,
    input  logic [RADDR_W-1:0]  ll_issue_rd,
    input  logic                ll_resp_valid,
    output logic                ll_resp_ready,
    input  logic [RADDR_W-1:0]  ll_resp_rd,
    input  logic [XLEN-1:0]     ll_resp_data,
    input  logic                wb_en,
    input  logic [RADDR_W-1:0]  wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic                wb_hold,
    output logic                rf_wr_en,
    output logic [RADDR_W-1:0]  rf_wr_addr,
    output logic [XLEN-1:0]     rf_wr_data,
    output logic [NUM_REGS-1:0] pending
);

    ll_result_t       buf_q;
    ll_result_t       buf_d;
    logic             buf_valid_q;
    logic             buf_valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic wb_real;
    logic force_buf;
    logic grant_buf;
    logic resp_fire;

    // A WB write to x0 is no write at all, so it never blocks the buffer.
    assign wb_real       = wb_en && (wb_addr != '0);
    assign force_buf     = buf_valid_q && (cnt_q == CNT_W'(STARVE_LIMIT));
    assign grant_buf     = buf_valid_q && (force_buf || !wb_real);
    assign ll_resp_ready = !buf_valid_q;
    assign resp_fire     = ll_resp_valid && ll_resp_ready;
    assign wb_hold       = force_buf && wb_real;

    // Write port mux; a buffered result for x0 drains without writing.
    always_comb begin
        rf_wr_en   = wb_real;
        rf_wr_addr = wb_addr;
        rf_wr_data = wb_data;
        if (grant_buf) begin
            rf_wr_en   = (buf_q.rd != '0);
            rf_wr_addr = buf_q.rd;
            rf_wr_data = buf_q.data;
        end
    end

    // Buffer and starvation counter next state. Acceptance only happens with
    // an empty buffer, so it never collides with a drain in the same cycle.
    always_comb begin
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        cnt_d       = cnt_q;
        if (grant_buf) begin
            buf_valid_d = 1'b0;
            cnt_d       = '0;
        end else if (wb_real && buf_valid_q &&
                     (cnt_q != CNT_W'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (resp_fire) begin
            buf_valid_d = 1'b1;
            buf_d.rd    = ll_resp_rd;
            buf_d.data  = ll_resp_data;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    gpr_wb_arbiter_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (ll_issue && (ll_issue_rd != '0)),
        .set_rd_i    (ll_issue_rd),
        .clr_en_i    (grant_buf),
        .clr_rd_i    (buf_q.rd),
        .id_valid_i  (id_valid),
        .id_rs1_i    (id_rs1_addr),
        .id_rs2_i    (id_rs2_addr),
        .id_rd_i     (id_rd_addr),
        .id_rd_wen_i (id_rd_wen),
        .id_stall_o  (id_stall),
        .pending_o   (pending)
    );

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: a behavioural model predicts every
// regfile write and the combinational handshakes; a monitor compares writes.
module tb_gpr_wb_arbiter;
    import gpr_wb_arbiter_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                id_valid, id_rd_wen, ll_issue, ll_resp_valid, wb_en;
    logic [RADDR_W-1:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [RADDR_W-1:0]  ll_issue_rd, ll_resp_rd, wb_addr;
    logic [XLEN-1:0]     ll_resp_data, wb_data;
    logic                id_stall, ll_resp_ready, wb_hold, rf_wr_en;
    logic [RADDR_W-1:0]  rf_wr_addr;
    logic [XLEN-1:0]     rf_wr_data;
    logic [NUM_REGS-1:0] pending;

    gpr_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen), .id_stall(id_stall),
        .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
        .ll_resp_valid(ll_resp_valid), .ll_resp_ready(ll_resp_ready),
        .ll_resp_rd(ll_resp_rd), .ll_resp_data(ll_resp_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_hold(wb_hold),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int               cyc;
        logic [RADDR_W-1:0] addr;
        logic [XLEN-1:0]  data;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: pending set, at most one waiting result and its age.
    bit [NUM_REGS-1:0] m_pend;
    bit                m_bv;
    logic [RADDR_W-1:0] m_brd;
    logic [XLEN-1:0]   m_bdata;
    int                m_wait;
    bit                last_hold, last_acc;

    // Random-driver bookkeeping.
    logic [RADDR_W-1:0] outstanding[$];
    bit                 offering;
    logic [RADDR_W-1:0] off_rd;
    logic [XLEN-1:0]    off_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_stall();
        return id_valid && (m_pend[id_rs1_addr] || m_pend[id_rs2_addr] ||
                            (id_rd_wen && m_pend[id_rd_addr]));
    endfunction

    task automatic idle();
        id_valid = 0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_rd_wen = 0;
        ll_issue = 0; ll_issue_rd = '0; ll_resp_valid = 0; ll_resp_rd = '0; ll_resp_data = '0;
        wb_en = 0; wb_addr = '0; wb_data = '0;
    endtask

    // Called at a falling edge with inputs applied; checks, predicts, advances.
    task automatic step();
        bit wb_real, frc, take_buf, hold, rdy;
        bit [NUM_REGS-1:0] n_pend;
        #1;
        wb_real  = wb_en && (wb_addr != 0);
        rdy      = !m_bv;
        frc      = m_bv && (m_wait == STARVE_LIMIT);
        hold     = frc && wb_real;
        take_buf = m_bv && (frc || !wb_real);
        chk("ready",   64'(ll_resp_ready), 64'(rdy));
        chk("wb_hold", 64'(wb_hold),       64'(hold));
        chk("stall",   64'(id_stall),      64'(model_stall()));
        chk("pending", 64'(pending),       64'(m_pend));
        if (take_buf) begin
            if (m_brd != 0) exp_q.push_back('{cyc, m_brd, m_bdata});
        end else if (wb_real) begin
            exp_q.push_back('{cyc, wb_addr, wb_data});
        end
        n_pend = m_pend;
        if (take_buf) begin
            n_pend[m_brd] = 0; m_bv = 0; m_wait = 0;
        end else if (wb_real && m_bv) begin
            m_wait++;
        end
        last_acc = ll_resp_valid && rdy;
        if (last_acc) begin
            m_bv = 1; m_brd = ll_resp_rd; m_bdata = ll_resp_data; m_wait = 0;
        end
        if (ll_issue && ll_issue_rd != 0) n_pend[ll_issue_rd] = 1;
        n_pend[0] = 0;
        m_pend    = n_pend;
        last_hold = hold;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_pend = '0; m_bv = 0; m_wait = 0; last_hold = 0; last_acc = 0;
        exp_q.delete(); outstanding.delete(); offering = 0;
    endtask

    task automatic rand_cycle();
        if (!last_hold) begin
            wb_en   = ($urandom_range(0, 3) != 0);
            wb_addr = RADDR_W'($urandom_range(0, 31));
            wb_data = {1'b0, 31'($urandom), 32'($urandom)};
        end
        id_valid    = 1'($urandom_range(0, 1));
        id_rs1_addr = RADDR_W'($urandom_range(0, 31));
        id_rs2_addr = RADDR_W'($urandom_range(0, 31));
        id_rd_addr  = RADDR_W'($urandom_range(0, 31));
        id_rd_wen   = 1'($urandom_range(0, 1));
        ll_issue    = 0;
        ll_issue_rd = '0;
        if (!offering && outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
            offering = 1;
            off_rd   = outstanding.pop_front();
            off_data = {1'b1, 31'($urandom), 32'($urandom)};
        end
        if (outstanding.size() < 3 && $urandom_range(0, 3) == 0) begin
            id_valid   = 1; id_rd_wen = 1;
            id_rd_addr = RADDR_W'($urandom_range(0, 31));
            if (!model_stall()) begin
                ll_issue    = 1;
                ll_issue_rd = id_rd_addr;
                outstanding.push_back(id_rd_addr);
            end
        end
        ll_resp_valid = offering;
        ll_resp_rd    = off_rd;
        ll_resp_data  = off_data;
        step();
        if (last_acc) offering = 0;
    endtask

    // Monitor: every port write must be the next predicted one, in its cycle.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (rf_wr_en) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write cyc=%0d got addr=%0d data=%0h exp none",
                                 cyc, rf_wr_addr, rf_wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                        chk("wr_addr",  64'(rf_wr_addr), 64'(e.addr));
                        chk("wr_data",  rf_wr_data, e.data);
                    end
                end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    checks++; errors++;
                    $display("FAIL missing_write cyc=%0d got none exp addr=%0d data=%0h",
                             cyc, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout cyc=%0d got running exp finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        off_rd = '0; off_data = '0;
        do_reset();

        // Plain WB write passes straight through.
        wb_en = 1; wb_addr = 5; wb_data = 64'hAA;
        #1;
        chk("t1_wr_en",  64'(rf_wr_en), 64'd1);
        chk("t1_addr",   64'(rf_wr_addr), 64'd5);
        chk("t1_data",   rf_wr_data, 64'hAA);
        chk("t1_pend",   64'(pending), 64'd0);
        chk("t1_stall",  64'(id_stall), 64'd0);
        step();

        // RAW on a long-latency destination.
        idle(); ll_issue = 1; ll_issue_rd = 7; id_valid = 1; id_rd_addr = 7; id_rd_wen = 1;
        step();
        idle(); id_valid = 1; id_rs1_addr = 7;
        #1; chk("t2_stall", 64'(id_stall), 64'd1);
        step();
        ll_resp_valid = 1; ll_resp_rd = 7; ll_resp_data = 64'h1234;
        step();
        ll_resp_valid = 0;
        #1; chk("t2_wr_addr", 64'(rf_wr_addr), 64'd7);
        step();
        #1; chk("t2_stall_drop", 64'(id_stall), 64'd0);
        step();

        // Starvation bound against continuous WB traffic.
        idle(); ll_issue = 1; ll_issue_rd = 9; step();
        idle(); ll_resp_valid = 1; ll_resp_rd = 9; ll_resp_data = 64'h99;
        wb_en = 1; wb_addr = 3; wb_data = 64'h33;
        step();
        ll_resp_valid = 0;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("t3_hold", 64'(wb_hold), (i == 8) ? 64'd1 : 64'd0);
            chk("t3_addr", 64'(rf_wr_addr), (i == 8) ? 64'd9 : 64'd3);
            step();
        end
        #1; chk("t3_retry", 64'(rf_wr_addr), 64'd3);
        step();

        // WAW on a long-latency destination.
        idle(); ll_issue = 1; ll_issue_rd = 4; step();
        idle(); id_valid = 1; id_rd_addr = 4; id_rd_wen = 1;
        #1; chk("t4_stall", 64'(id_stall), 64'd1);
        step();
        ll_resp_valid = 1; ll_resp_rd = 4; ll_resp_data = 64'h44;
        step();
        ll_resp_valid = 0;
        step();
        #1; chk("t4_stall_drop", 64'(id_stall), 64'd0);
        step();

        // Back-to-back responses: ready goes 1,0,1.
        idle(); ll_issue = 1; ll_issue_rd = 10; step();
        ll_issue_rd = 11; step();
        idle(); ll_resp_valid = 1; ll_resp_rd = 10; ll_resp_data = 64'hA0;
        #1; chk("t5_rdy0", 64'(ll_resp_ready), 64'd1);
        step();
        ll_resp_rd = 11; ll_resp_data = 64'hB0;
        #1; chk("t5_rdy1", 64'(ll_resp_ready), 64'd0);
        step();
        #1; chk("t5_rdy2", 64'(ll_resp_ready), 64'd1);
        step();
        idle(); step(); step();

        // Destination x0: nothing pending, nothing written, still drains.
        ll_issue = 1; ll_issue_rd = 0; step();
        idle();
        #1; chk("t6_pend", 64'(pending), 64'd0);
        ll_resp_valid = 1; ll_resp_rd = 0; ll_resp_data = 64'hDEAD;
        step();
        idle();
        #1; chk("t6_no_wr", 64'(rf_wr_en), 64'd0);
        step();
        #1; chk("t6_rdy", 64'(ll_resp_ready), 64'd1);
        step();

        // Randomised traffic, a reset in the middle, more traffic, then drain.
        for (int i = 0; i < 1500; i++) rand_cycle();
        do_reset();
        #1; chk("rst_pend", 64'(pending), 64'd0);
        chk("rst_rdy", 64'(ll_resp_ready), 64'd1);
        step();
        for (int i = 0; i < 1000; i++) rand_cycle();
        for (int i = 0; i < 20; i++) begin
            if (!last_hold) wb_en = 0;
            id_valid = 0; ll_issue = 0;
            ll_resp_valid = offering; ll_resp_rd = off_rd; ll_resp_data = off_data;
            step();
            if (last_acc) offering = 0;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
